// File: rtl/dmem_access_unit.sv
// MEM-stage load/store initiator for the word-addressed data memory.
// Byte and halfword stores use read-modify-write; loads are sign- or
// zero-extended. The pipeline is stalled until the access completes.
module dmem_access_unit #(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        dmem_memwrite,
  output logic        dmem_memread,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_RMW_RD = 3'd2,
    S_WR     = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t            state_r;
  logic [1:0]        lane_r;
  logic [1:0]        size_r;
  logic              uns_r;
  logic [31:0]       wdata_r;

  logic              accept_s;
  logic              misalign_s;
  logic              range_bad_s;
  logic              size_bad_s;
  logic              req_err_s;
  logic [IDX_W-1:0]  idx_s;

  // Extract the addressed byte/half lane from a memory word and extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [1:0]  size,
                                              input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      2'd0:    r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'd1:    r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace only the addressed lane(s) of a memory word with store data.
  function automatic logic [31:0] merge_store(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [1:0]  size,
                                              input logic [31:0] wdata);
    logic [31:0] r;
    r = word;
    case (size)
      2'd0:    r[{lane, 3'b000} +: 8] = wdata[7:0];
      2'd1:    r[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default: r = wdata;
    endcase
    return r;
  endfunction

  assign accept_s = req_valid & (req_read | req_write);
  assign stall    = (state_r != S_IDLE);

  // Decode word index and classify the incoming request as legal or not.
  always_comb begin
    idx_s       = req_addr[IDX_W+1:2];
    size_bad_s  = (req_size == 2'd3);
    range_bad_s = ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));
    if (req_size == 2'd1) begin
      misalign_s = req_addr[0];
    end else if (req_size == 2'd2) begin
      misalign_s = (req_addr[1:0] != 2'd0);
    end else begin
      misalign_s = 1'b0;
    end
    req_err_s = size_bad_s | misalign_s | range_bad_s;
  end

  // Access sequencer: state, captured request fields and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= S_IDLE;
      lane_r        <= 2'd0;
      size_r        <= 2'd0;
      uns_r         <= 1'b0;
      wdata_r       <= 32'd0;
      dmem_addr     <= 32'd0;
      dmem_wdata    <= 32'd0;
      dmem_memwrite <= 1'b0;
      dmem_memread  <= 1'b0;
      resp_valid    <= 1'b0;
      resp_rdata    <= 32'd0;
      resp_err      <= 1'b0;
    end else begin
      dmem_memread  <= 1'b0;
      dmem_memwrite <= 1'b0;
      resp_valid    <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            lane_r  <= req_addr[1:0];
            size_r  <= req_size;
            uns_r   <= req_unsigned;
            wdata_r <= req_wdata;
            if (req_err_s) begin
              state_r    <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
            end else if (req_write) begin
              // A write wins over a simultaneous read.
              dmem_addr <= {{(32-IDX_W){1'b0}}, idx_s};
              if (req_size == 2'd2) begin
                state_r       <= S_WR;
                dmem_memwrite <= 1'b1;
                dmem_wdata    <= req_wdata;
              end else begin
                state_r      <= S_RMW_RD;
                dmem_memread <= 1'b1;
              end
            end else begin
              dmem_addr    <= {{(32-IDX_W){1'b0}}, idx_s};
              state_r      <= S_RD;
              dmem_memread <= 1'b1;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_RD: begin
          state_r    <= S_RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= load_extend(dmem_rdata, lane_r, size_r, uns_r);
        end
        S_RMW_RD: begin
          state_r       <= S_WR;
          dmem_memwrite <= 1'b1;
          dmem_wdata    <= merge_store(dmem_rdata, lane_r, size_r, wdata_r);
        end
        S_WR: begin
          state_r    <= S_RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'd0;
        end
        S_RESP: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit with a transaction-level memory model
// and a per-cycle expectation queue checked on the falling clock edge.
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_read, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, resp_rdata;
  logic        dmem_memwrite, dmem_memread, stall, resp_valid, resp_err;

  dmem_access_unit #(.DEPTH_WORDS(256), .IDX_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_read(req_read), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_memwrite(dmem_memwrite), .dmem_memread(dmem_memread),
    .dmem_rdata(dmem_rdata),
    .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  // attached memory: asynchronous read, synchronous write
  logic [31:0] mem [256];
  assign dmem_rdata = mem[dmem_addr[7:0]];
  always @(posedge clk) begin
    if (dmem_memwrite) mem[dmem_addr[7:0]] <= dmem_wdata;
  end

  // reference memory, updated per transaction
  logic [31:0] ref_mem [256];
  logic [31:0] held_rdata;
  logic [31:0] last_addr;

  typedef struct packed {
    logic        stall, rd, wr, rv, err;
    logic [31:0] addr, wdata, rdata;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_err = 0;
  bit chk_idle = 1'b0;
  int stall_cnt = 0;
  logic [31:0] cap_rdata;
  logic        cap_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic s, input logic rd, input logic wr, input logic rv,
                          input logic err, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rdat);
    exp_t e;
    e.stall = s; e.rd = rd; e.wr = wr; e.rv = rv; e.err = err;
    e.addr = a; e.wdata = wd; e.rdata = rdat;
    exp_q.push_back(e);
  endtask

  // per-cycle compare against the expectation queue, idle checks otherwise
  always @(negedge clk) begin
    exp_t e;
    if (stall) stall_cnt++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stall", {31'd0, stall}, {31'd0, e.stall});
      chk("memread", {31'd0, dmem_memread}, {31'd0, e.rd});
      chk("memwrite", {31'd0, dmem_memwrite}, {31'd0, e.wr});
      chk("resp_valid", {31'd0, resp_valid}, {31'd0, e.rv});
      chk("dmem_addr", dmem_addr, e.addr);
      chk("resp_rdata", resp_rdata, e.rdata);
      if (e.wr) chk("dmem_wdata", dmem_wdata, e.wdata);
      if (e.rv) begin
        chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        cap_rdata = resp_rdata;
        cap_err   = resp_err;
      end
    end else if (chk_idle) begin
      chk("idle_stall", {31'd0, stall}, 32'd0);
      chk("idle_rd", {31'd0, dmem_memread}, 32'd0);
      chk("idle_wr", {31'd0, dmem_memwrite}, 32'd0);
      chk("idle_rv", {31'd0, resp_valid}, 32'd0);
    end
  end

  task automatic clear_req();
    req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
    req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
  endtask

  // Issue one request, queue the expected cycle trace, wait for it to drain,
  // then pin the model with hand-computed literals.
  task automatic do_req(input string name, input logic rd, input logic wr,
                        input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input logic hold,
                        input logic [31:0] lit_rdata, input logic lit_err, input int lit_stall);
    logic        err;
    logic [7:0]  idx;
    int          sh;
    int          n;
    int          k;
    logic [31:0] old, mask, newv, res;
    err = (sz == 2'd3) || (sz == 2'd1 && addr[0]) ||
          (sz == 2'd2 && addr[1:0] != 2'd0) || (addr >= 32'd1024);
    idx = addr[9:2];
    old = ref_mem[idx];
    sh  = 8 * addr[1:0];
    @(negedge clk);
    stall_cnt = 0;
    req_valid = 1'b1; req_read = rd; req_write = wr; req_size = sz;
    req_unsigned = uns; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1;
    clear_req();
    if (err) begin
      push_exp(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, last_addr, 32'd0, 32'd0);
      held_rdata = 32'd0; n = 1;
    end else if (wr && sz == 2'd2) begin
      last_addr = {24'd0, idx};
      push_exp(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, last_addr, wd, held_rdata);
      push_exp(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, last_addr, 32'd0, 32'd0);
      held_rdata = 32'd0; ref_mem[idx] = wd; n = 2;
    end else if (wr) begin
      last_addr = {24'd0, idx};
      mask = ((sz == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
      newv = (old & ~mask) | ((wd << sh) & mask);
      push_exp(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, last_addr, 32'd0, held_rdata);
      push_exp(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, last_addr, newv, held_rdata);
      push_exp(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, last_addr, 32'd0, 32'd0);
      held_rdata = 32'd0; ref_mem[idx] = newv; n = 3;
    end else begin
      last_addr = {24'd0, idx};
      res = old >> sh;
      if (sz == 2'd0) begin
        res = res & 32'h0000_00FF;
        if (!uns && res >= 32'd128) res = res | 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
        res = res & 32'h0000_FFFF;
        if (!uns && res >= 32'd32768) res = res | 32'hFFFF_0000;
      end
      push_exp(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, last_addr, 32'd0, held_rdata);
      push_exp(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, last_addr, 32'd0, res);
      held_rdata = res; n = 2;
    end
    push_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, last_addr, 32'd0, held_rdata);
    if (hold) begin
      // a competing write held high during the stall must be ignored
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2;
      req_addr = 32'h0000_0040; req_wdata = 32'hDEAD_BEEF;
      repeat (n) @(posedge clk);
      #1;
      clear_req();
    end
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      chk({name, "_drain"}, exp_q.size(), 32'd0);
      exp_q.delete();
    end
    chk({name, "_lit_rdata"}, cap_rdata, lit_rdata);
    chk({name, "_lit_err"}, {31'd0, cap_err}, {31'd0, lit_err});
    chk({name, "_lit_stall"}, stall_cnt, lit_stall);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'h0101_0101 * i ^ 32'h5A00_0000;
      ref_mem[i] = 32'h0101_0101 * i ^ 32'h5A00_0000;
    end
    mem[7] = 32'h0000_0007;     ref_mem[7] = 32'h0000_0007;
    mem[3] = 32'h1234_F0AB;     ref_mem[3] = 32'h1234_F0AB;
    mem[2] = 32'h1122_3344;     ref_mem[2] = 32'h1122_3344;
    mem[255] = 32'h8000_8001;   ref_mem[255] = 32'h8000_8001;
    clear_req();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_rv", {31'd0, resp_valid}, 32'd0);
    chk("rst_rd", {31'd0, dmem_memread}, 32'd0);
    chk("rst_wr", {31'd0, dmem_memwrite}, 32'd0);
    rst_n = 1'b1;

    // reset during a pending load abandons it
    @(negedge clk);
    req_valid = 1'b1; req_read = 1'b1; req_size = 2'd2; req_addr = 32'h0000_001C;
    @(posedge clk);
    #1;
    clear_req();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rstp_stall", {31'd0, stall}, 32'd0);
    chk("rstp_rv", {31'd0, resp_valid}, 32'd0);
    chk("rstp_rd", {31'd0, dmem_memread}, 32'd0);
    chk("rstp_wr", {31'd0, dmem_memwrite}, 32'd0);
    chk("rstp_addr", dmem_addr, 32'd0);
    chk("rstp_wdata", dmem_wdata, 32'd0);
    chk("rstp_rdata", resp_rdata, 32'd0);
    chk("rstp_err", {31'd0, resp_err}, 32'd0);
    rst_n = 1'b1;
    held_rdata = 32'd0;
    last_addr  = 32'd0;
    cap_rdata  = 32'd0;
    cap_err    = 1'b0;
    chk_idle   = 1'b1;
    repeat (4) @(negedge clk);

    //     name      rd    wr    sz    uns   addr          wdata         hold  lit_rdata     err   stall
    do_req("ldw",    1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_001C, 32'd0,        1'b0, 32'h0000_0007, 1'b0, 2);
    do_req("ldb_s",  1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_000D, 32'd0,        1'b0, 32'hFFFF_FFF0, 1'b0, 2);
    do_req("ldb_u",  1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_000D, 32'd0,        1'b1, 32'h0000_00F0, 1'b0, 2);
    do_req("sth",    1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_000A, 32'h0000_BEEF, 1'b0, 32'h0000_0000, 1'b0, 3);
    do_req("ldw2",   1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0008, 32'd0,        1'b0, 32'hBEEF_3344, 1'b0, 2);
    do_req("ldh_s",  1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_000A, 32'd0,        1'b0, 32'hFFFF_BEEF, 1'b0, 2);
    do_req("ldh_u",  1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0008, 32'd0,        1'b0, 32'h0000_3344, 1'b0, 2);
    do_req("err_w",  1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'd0,        1'b0, 32'h0000_0000, 1'b1, 1);
    do_req("err_h",  1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0003, 32'h1111_1111, 1'b0, 32'h0000_0000, 1'b1, 1);
    do_req("err_rg", 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0400, 32'd0,        1'b0, 32'h0000_0000, 1'b1, 1);
    do_req("err_sz", 1'b1, 1'b0, 2'd3, 1'b0, 32'h0000_0010, 32'd0,        1'b0, 32'h0000_0000, 1'b1, 1);
    do_req("rdwr",   1'b1, 1'b1, 2'd2, 1'b0, 32'h0000_0020, 32'hCAFE_F00D, 1'b0, 32'h0000_0000, 1'b0, 2);
    do_req("ldw3",   1'b1, 1'b0, 2'd2, 1'b1, 32'h0000_0020, 32'd0,        1'b0, 32'hCAFE_F00D, 1'b0, 2);
    do_req("stb",    1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_000F, 32'h0000_005A, 1'b0, 32'h0000_0000, 1'b0, 3);
    do_req("ldb3",   1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_000F, 32'd0,        1'b0, 32'h0000_005A, 1'b0, 2);
    do_req("ldw4",   1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_000C, 32'd0,        1'b0, 32'h5A34_F0AB, 1'b0, 2);
    do_req("ldtop",  1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_03FC, 32'd0,        1'b0, 32'hFFFF_8001, 1'b0, 2);
    do_req("ldw5",   1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'd0,        1'b0, 32'h5A00_0000 ^ (32'h0101_0101 * 32'd16), 1'b0, 2);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
